// File: rtl/stream_capture_ctrl.sv
// ---------------------------------------------------------------------------
// stream_capture_ctrl
//
// Capture sequencer for one logic-analyzer channel. It drives both sides of
// a single-clock stream FIFO and turns it into a pre-/post-trigger capture
// buffer:
//   PRE   : every sample is written; the oldest sample is dropped so that the
//           FIFO holds a rolling window of the most recent pre_r samples.
//   POST  : after an accepted trigger, post_r samples (trigger included) are
//           written with no drops.
//   READ  : the FIFO output is handed to the host readout stream.
//   FLUSH : after an abort, the FIFO is drained and the contents discarded.
//
// Handshakes: a transfer happens on a side in every cycle where both valid
// and ready are high on the rising clock edge. The sample source has no
// backpressure; the window clamping guarantees that fifo_din_ready is high
// whenever this block asserts fifo_din_valid during a capture.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset (shared with
//                         the FIFO instance)
//   arm                 : start a capture (IDLE only); latches pre/post counts
//   abort               : cancel capture (PRE, POST, READ) -> FLUSH
//   pre_count           : requested pre-trigger samples
//   post_count          : requested post-trigger samples, trigger included
//   sample_valid/data   : incoming sample stream
//   trigger             : current sample is the trigger (with sample_valid)
//   fifo_din_*          : FIFO write side
//   fifo_dout_*         : FIFO read side
//   fifo_used           : FIFO occupancy before this cycle's operations
//   rd_valid/ready/data : host readout stream
//   state               : IDLE=0, PRE=1, POST=2, READ=3, FLUSH=4
//   busy                : state != IDLE
//   capture_done        : one-cycle pulse in the cycle that moves to READ
// ---------------------------------------------------------------------------
module stream_capture_ctrl #(
  parameter int Width = 8,
  parameter int Depth = 128,
  localparam int CW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic [CW-1:0]    pre_count,
  input  logic [CW-1:0]    post_count,
  input  logic             sample_valid,
  input  logic [Width-1:0] sample_data,
  input  logic             trigger,
  output logic             fifo_din_valid,
  input  logic             fifo_din_ready,
  output logic [Width-1:0] fifo_din_data,
  input  logic             fifo_dout_valid,
  output logic             fifo_dout_ready,
  input  logic [Width-1:0] fifo_dout_data,
  input  logic [CW-1:0]    fifo_used,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [Width-1:0] rd_data,
  output logic [2:0]       state,
  output logic             busy,
  output logic             capture_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_POST  = 3'd2,
    ST_READ  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  localparam logic [CW-1:0] DEPTH_C    = CW'(Depth);
  localparam logic [CW-1:0] DEPTH_M1_C = CW'(Depth - 1);
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] pre_r_q, pre_r_d;
  logic [CW-1:0] post_r_q, post_r_d;
  logic [CW-1:0] post_cnt_q, post_cnt_d;
  // High during the first READ cycle only: the FIFO's empty/used view lags
  // the last POST write by a cycle, so an empty indication there is stale.
  logic          read_first_q, read_first_d;

  // -------------------------------------------------------------------------
  // Configuration clamping. pre_r leaves at least one slot for the trigger
  // sample and post_r never exceeds the remaining room, so the FIFO cannot
  // overflow before READ.
  // -------------------------------------------------------------------------
  logic [CW-1:0] pre_clamp;
  logic [CW-1:0] post_min1;
  logic [CW-1:0] post_room;
  logic [CW-1:0] post_clamp;

  always_comb begin
    pre_clamp  = (pre_count > DEPTH_M1_C) ? DEPTH_M1_C : pre_count;
    post_min1  = (post_count == '0) ? ONE_C : post_count;
    post_room  = DEPTH_C - pre_clamp;
    post_clamp = (post_min1 > post_room) ? post_room : post_min1;
  end

  // -------------------------------------------------------------------------
  // Trigger qualification and sample bookkeeping.
  // A trigger is only honoured once the pre-window is full; this is what
  // makes the readout always contain exactly pre_r samples before it.
  // -------------------------------------------------------------------------
  logic          trig_acc;
  logic          sample_wr;
  logic [CW-1:0] post_cnt_inc;

  assign trig_acc     = (state_q == ST_PRE) & sample_valid & trigger &
                        (fifo_used >= pre_r_q);
  assign sample_wr    = sample_valid & fifo_din_ready;
  assign post_cnt_inc = post_cnt_q + ONE_C;

  // Data paths are pure pass-through: zero added latency in both directions.
  assign fifo_din_data = sample_data;
  assign rd_data       = fifo_dout_data;
  assign state         = state_q;
  assign busy          = (state_q != ST_IDLE);

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    pre_r_d         = pre_r_q;
    post_r_d        = post_r_q;
    post_cnt_d      = post_cnt_q;
    read_first_d    = 1'b0;
    fifo_din_valid  = 1'b0;
    fifo_dout_ready = 1'b0;
    rd_valid        = 1'b0;
    capture_done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          pre_r_d    = pre_clamp;
          post_r_d   = post_clamp;
          post_cnt_d = '0;
          state_d    = ST_PRE;
        end
      end

      ST_PRE: begin
        fifo_din_valid = sample_valid;
        // Drop the oldest sample when the window is over-full, or when it is
        // exactly full and a non-trigger sample is about to be written. A
        // drop and a write can share a cycle, keeping occupancy at pre_r.
        fifo_dout_ready = fifo_dout_valid &
                          ((fifo_used > pre_r_q) |
                           ((fifo_used == pre_r_q) & sample_valid & ~trig_acc));
        if (abort) begin
          state_d = ST_FLUSH;
        end else if (trig_acc) begin
          post_cnt_d = ONE_C;
          if (post_r_q == ONE_C) begin
            state_d      = ST_READ;
            read_first_d = 1'b1;
            capture_done = 1'b1;
          end else begin
            state_d = ST_POST;
          end
        end
      end

      ST_POST: begin
        fifo_din_valid = sample_valid;
        if (abort) begin
          state_d = ST_FLUSH;
        end else if (sample_wr) begin
          post_cnt_d = post_cnt_inc;
          if (post_cnt_inc == post_r_q) begin
            state_d      = ST_READ;
            read_first_d = 1'b1;
            capture_done = 1'b1;
          end
        end
      end

      ST_READ: begin
        rd_valid        = fifo_dout_valid;
        fifo_dout_ready = rd_ready;
        if (abort) begin
          state_d = ST_FLUSH;
        end else if (!read_first_q && !fifo_dout_valid) begin
          state_d = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        fifo_dout_ready = 1'b1;
        if (!fifo_dout_valid) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pre_r_q      <= '0;
      post_r_q     <= ONE_C;
      post_cnt_q   <= '0;
      read_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_r_q      <= pre_r_d;
      post_r_q     <= post_r_d;
      post_cnt_q   <= post_cnt_d;
      read_first_q <= read_first_d;
    end
  end

endmodule

// File: tb/tb_stream_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stream_capture_ctrl
//
// Bench for stream_capture_ctrl with a small behavioural FIFO attached.
// The reference model describes a capture as "the last pre_r samples before
// the accepted trigger, the trigger, then the following samples until the
// window holds pre_r + post_r", and the expected readout is kept in exp_q.
// ---------------------------------------------------------------------------
module tb_stream_capture_ctrl;
  localparam int Width = 8;
  localparam int Depth = 16;
  localparam int CW    = $clog2(Depth + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             arm, abort, sample_valid, trigger, rd_ready;
  logic [CW-1:0]    pre_count, post_count;
  logic [Width-1:0] sample_data;
  logic             fifo_din_valid, fifo_din_ready, fifo_dout_valid, fifo_dout_ready;
  logic [Width-1:0] fifo_din_data, fifo_dout_data, rd_data;
  logic [CW-1:0]    fifo_used;
  logic             rd_valid, busy, capture_done;
  logic [2:0]       state;

  stream_capture_ctrl #(.Width(Width), .Depth(Depth)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .pre_count(pre_count), .post_count(post_count),
    .sample_valid(sample_valid), .sample_data(sample_data), .trigger(trigger),
    .fifo_din_valid(fifo_din_valid), .fifo_din_ready(fifo_din_ready),
    .fifo_din_data(fifo_din_data),
    .fifo_dout_valid(fifo_dout_valid), .fifo_dout_ready(fifo_dout_ready),
    .fifo_dout_data(fifo_dout_data), .fifo_used(fifo_used),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .state(state), .busy(busy), .capture_done(capture_done)
  );

  // behavioural FIFO attached to the DUT
  logic [Width-1:0] fmem [Depth];
  int f_rd, f_wr, f_cnt;
  assign fifo_dout_valid = (f_cnt != 0);
  assign fifo_dout_data  = fmem[f_rd];
  assign fifo_din_ready  = (f_cnt < Depth);
  assign fifo_used       = CW'(f_cnt);

  always @(posedge clk) begin
    bit w, r;
    if (rst) begin
      f_rd <= 0; f_wr <= 0; f_cnt <= 0;
    end else begin
      w = fifo_din_valid && (f_cnt < Depth);
      r = fifo_dout_ready && (f_cnt != 0);
      if (w) begin
        fmem[f_wr] <= fifo_din_data;
        f_wr <= (f_wr + 1) % Depth;
      end
      if (r) f_rd <= (f_rd + 1) % Depth;
      f_cnt <= f_cnt + int'(w) - int'(r);
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  logic [Width-1:0] exp_q[$];
  logic [Width-1:0] hist[$];
  logic [Width-1:0] got_q[$];
  int ph = 0;        // 0 idle, 1 pre-window, 2 post, 3 readout, 4 flush
  int m_pre = 0;
  int m_post = 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // compare process: runs every cycle, 2 time units after the input update
  always @(negedge clk) begin
    #2;
    if (rst) begin
      ph = 0;
      exp_q.delete();
      hist.delete();
    end else begin
      int  nph;
      int  sz;
      int  p;
      bit  cd;
      bit  exp_rdv;
      nph = ph;
      cd  = 1'b0;
      sz  = exp_q.size();
      exp_rdv = (ph == 3) && (sz > 0);

      chk("state", state, ph);
      chk("busy", busy, ph != 0);
      chk("din_valid", fifo_din_valid, ((ph == 1) || (ph == 2)) && sample_valid);
      if (fifo_din_valid) begin
        chk("din_data", fifo_din_data, sample_data);
        chk("din_ready", fifo_din_ready, 1);
      end
      chk("rd_valid", rd_valid, exp_rdv);
      chk("rd_data_pass", rd_data, fifo_dout_data);
      case (ph)
        1:       chk("pre_occupancy", f_cnt <= ((m_pre > 1) ? m_pre : 1), 1);
        3:       chk("dout_ready_read", fifo_dout_ready, rd_ready);
        4:       chk("dout_ready_flush", fifo_dout_ready, 1);
        default: chk("dout_ready_off", fifo_dout_ready, 0);
      endcase

      if (exp_rdv && rd_ready) begin
        chk("rd_data", rd_data, exp_q[0]);
        got_q.push_back(rd_data);
        void'(exp_q.pop_front());
      end

      case (ph)
        0: if (arm) begin
          m_pre  = (int'(pre_count) > Depth - 1) ? Depth - 1 : int'(pre_count);
          p      = (post_count == '0) ? 1 : int'(post_count);
          m_post = (p > Depth - m_pre) ? Depth - m_pre : p;
          hist.delete();
          exp_q.delete();
          nph = 1;
        end
        1: if (abort) begin
          nph = 4;
        end else if (sample_valid) begin
          if (trigger && (hist.size() >= m_pre)) begin
            exp_q = hist;
            exp_q.push_back(sample_data);
            if (exp_q.size() == m_pre + m_post) begin
              nph = 3; cd = 1'b1;
            end else begin
              nph = 2;
            end
          end else begin
            hist.push_back(sample_data);
            if (hist.size() > m_pre) void'(hist.pop_front());
          end
        end
        2: if (abort) begin
          nph = 4;
        end else if (sample_valid) begin
          exp_q.push_back(sample_data);
          if (exp_q.size() == m_pre + m_post) begin
            nph = 3; cd = 1'b1;
          end
        end
        3: if (abort) begin
          nph = 4;
          exp_q.delete();
        end else if (sz == 0) begin
          nph = 0;
        end
        default: if (f_cnt == 0) nph = 0;
      endcase

      chk("capture_done", capture_done, cd);
      if (cd) n_done++;
      ph = nph;
    end
  end

  // driver tasks
  task automatic idle_inputs();
    arm = 1'b0; abort = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
    sample_data = '0; rd_ready = 1'b0; pre_count = '0; post_count = '0;
  endtask

  task automatic do_arm(input int pre, input int post);
    @(negedge clk);
    idle_inputs();
    got_q.delete();
    n_done = 0;
    arm = 1'b1;
    pre_count = CW'(pre);
    post_count = CW'(post);
  endtask

  // Samples until the model leaves PRE/POST. Data is the sample index unless
  // rnd is set. abort_at counts valid samples taken while in POST.
  task automatic feed(input int trig_at, input bit hold, input int gap_pct,
                      input bit rnd, input int abort_at);
    int  k = 0;
    int  npost = 0;
    bit  left = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (ph != 1 && ph != 2) begin
        idle_inputs();
        left = 1'b1;
        break;
      end
      arm = 1'b0; abort = 1'b0;
      pre_count = CW'($urandom_range(0, 31));
      post_count = CW'($urandom_range(0, 31));
      rd_ready = 1'(($urandom_range(0, 1)));
      sample_valid = ($urandom_range(0, 99) >= gap_pct);
      sample_data = rnd ? Width'($urandom) : Width'(k);
      if (sample_valid) begin
        trigger = hold ? (k >= trig_at) : (k == trig_at);
        if (ph == 2) begin
          npost++;
          if (npost == abort_at) abort = 1'b1;
        end
        k++;
      end else begin
        trigger = 1'(($urandom_range(0, 1)));
      end
    end
    chk("feed_finished", left, 1);
  endtask

  // Runs READ / FLUSH to IDLE. rdy_mode 0: always ready, 1: 1,0,0,1 pattern,
  // 2: random. noise drives arm/trigger/samples that must be ignored.
  task automatic drain(input int rdy_mode, input bit noise, input int abort_pct);
    int pat[4] = '{1, 0, 0, 1};
    bit left = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (ph == 0) begin
        idle_inputs();
        left = 1'b1;
        break;
      end
      arm = noise ? 1'(($urandom_range(0, 1))) : 1'b0;
      trigger = noise ? 1'(($urandom_range(0, 1))) : 1'b0;
      sample_valid = noise ? 1'(($urandom_range(0, 1))) : 1'b0;
      sample_data = Width'($urandom);
      abort = ($urandom_range(0, 99) < abort_pct);
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'(pat[c % 4]);
        default: rd_ready = 1'(($urandom_range(0, 1)));
      endcase
    end
    chk("drain_finished", left, 1);
  endtask

  task automatic chk_window(input string name, input int n, input int first);
    chk({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < got_q.size() && i < n; i++)
      chk({name, "_data"}, got_q[i], first + i);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("reset_state", state, 0);
    chk("reset_busy", busy, 0);
    chk("reset_capture_done", capture_done, 0);
    chk("reset_din_valid", fifo_din_valid, 0);
    chk("reset_dout_ready", fifo_dout_ready, 0);
    chk("reset_rd_valid", rd_valid, 0);

    // basic window: trigger at sample 10 -> readout 6..13
    do_arm(4, 4);
    feed(10, 1'b0, 0, 1'b0, -1);
    drain(0, 1'b0, 0);
    chk_window("basic", 8, 6);
    chk("basic_done_pulses", n_done, 1);

    // early trigger held from sample 0 -> first accepted is sample 4
    do_arm(4, 4);
    feed(0, 1'b1, 0, 1'b0, -1);
    drain(0, 1'b0, 0);
    chk_window("early", 8, 0);

    // zero pre-window with gaps -> readout {7}
    do_arm(0, 1);
    feed(7, 1'b0, 40, 1'b0, -1);
    drain(0, 1'b0, 0);
    chk_window("zero_pre", 1, 7);
    chk("zero_pre_done_pulses", n_done, 1);

    // clamping: pre 20 -> 15, post 20 -> 1 -> readout 0..15
    do_arm(20, 20);
    feed(0, 1'b1, 0, 1'b0, -1);
    drain(0, 1'b0, 0);
    chk_window("clamp", 16, 0);

    // abort on the 2nd sample taken in POST -> flush, nothing read
    do_arm(3, 6);
    feed(5, 1'b0, 0, 1'b0, 2);
    drain(0, 1'b0, 0);
    chk("abort_reads", got_q.size(), 0);
    chk("abort_fifo_empty", f_cnt, 0);
    do_arm(2, 3);
    feed(4, 1'b0, 0, 1'b0, -1);
    drain(0, 1'b0, 0);
    chk_window("after_abort", 5, 2);

    // host backpressure 1,0,0,1 with ignored arm/trigger noise in READ
    do_arm(3, 3);
    feed(6, 1'b0, 0, 1'b0, -1);
    drain(1, 1'b1, 0);
    chk_window("backpressure", 6, 3);

    // reset in the middle of a capture
    do_arm(3, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      arm = 1'b0; sample_valid = 1'b1; sample_data = Width'(i); trigger = 1'b0;
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("midreset_state", state, 0);
    chk("midreset_fifo", f_cnt, 0);

    // randomized captures
    for (int n = 0; n < 40; n++) begin
      int pre, post, ta, ab;
      bit hold;
      pre  = $urandom_range(0, 20);
      post = $urandom_range(0, 20);
      hold = 1'($urandom_range(0, 1));
      ta   = hold ? $urandom_range(0, 20) : pre + $urandom_range(0, 10);
      ab   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : -1;
      do_arm(pre, post);
      feed(ta, hold, $urandom_range(0, 50), 1'b1, ab);
      drain(2, 1'b1, 3);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
